// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, default PROT and the master FSM states.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DONE
    } state_t;

    // Anything other than OKAY, EXOKAY included, is reported to the requester as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Transaction watchdog: counts cycles while run is high, flags when the count reaches TIMEOUT_CYCLES.
// Latency: expired is combinational from the count; count clears one cycle after run drops.
// Backpressure: none, free-running while run is high and saturating at the limit.
module axil_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/axil_lite_master.sv
// Native valid/ready memory port to AXI4-Lite master bridge, one transaction in flight.
// Latency: mem_ready pulses one cycle after the B/R handshake (3 cycles with a zero-wait slave).
// Backpressure: mem_valid is held until mem_ready; AXI VALIDs hold until handshake.
// Optional watchdog abort enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_lite_master
    import axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,

    output logic [31:0] M_AWADDR,
    output logic [2:0]  M_AWPROT,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_WSTRB,
    output logic        M_WVALID,
    input  logic        M_WREADY,
    input  logic [1:0]  M_BRESP,
    input  logic        M_BVALID,
    output logic        M_BREADY,
    output logic [31:0] M_ARADDR,
    output logic [2:0]  M_ARPROT,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [31:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RVALID,
    output logic        M_RREADY
);

    state_t state;
    logic   expired;
    logic   aw_done;
    logic   w_done;

    assign M_AWPROT = PROT_DEFAULT;
    assign M_ARPROT = PROT_DEFAULT;

    // A channel counts as done once its VALID has dropped or is being accepted this cycle.
    assign aw_done = !M_AWVALID || M_AWREADY;
    assign w_done  = !M_WVALID  || M_WREADY;

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic busy;
    assign busy = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                  (state == ST_RD_REQ) || (state == ST_RD_RESP);

    axil_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .aclk    (aclk),
        .aresetn (aresetn),
        .run     (busy),
        .expired (expired)
    );
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES == 0);
    assign expired        = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            mem_err   <= 1'b0;
            M_AWADDR  <= '0;
            M_AWVALID <= 1'b0;
            M_WDATA   <= '0;
            M_WSTRB   <= '0;
            M_WVALID  <= 1'b0;
            M_BREADY  <= 1'b0;
            M_ARADDR  <= '0;
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_valid) begin
                        if (mem_wstrb != 4'b0000) begin
                            M_AWADDR  <= mem_addr;
                            M_WDATA   <= mem_wdata;
                            M_WSTRB   <= mem_wstrb;
                            M_AWVALID <= 1'b1;
                            M_WVALID  <= 1'b1;
                            state     <= ST_WR_REQ;
                        end else begin
                            M_ARADDR  <= mem_addr;
                            M_ARVALID <= 1'b1;
                            state     <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (M_AWVALID && M_AWREADY) M_AWVALID <= 1'b0;
                    if (M_WVALID && M_WREADY)   M_WVALID  <= 1'b0;
                    if (aw_done && w_done) begin
                        M_BREADY <= 1'b1;
                        state    <= ST_WR_RESP;
                    end else if (expired) begin
                        M_AWVALID <= 1'b0;
                        M_WVALID  <= 1'b0;
                        mem_err   <= 1'b1;
                        mem_rdata <= '0;
                        mem_ready <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_WR_RESP: begin
                    if (M_BVALID) begin
                        M_BREADY  <= 1'b0;
                        mem_err   <= resp_is_err(M_BRESP);
                        mem_rdata <= '0;
                        mem_ready <= 1'b1;
                        state     <= ST_DONE;
                    end else if (expired) begin
                        M_BREADY  <= 1'b0;
                        mem_err   <= 1'b1;
                        mem_rdata <= '0;
                        mem_ready <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_RD_REQ: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                        state     <= ST_RD_RESP;
                    end else if (expired) begin
                        M_ARVALID <= 1'b0;
                        mem_err   <= 1'b1;
                        mem_rdata <= '0;
                        mem_ready <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_RD_RESP: begin
                    // Read data is forwarded even on an error response.
                    if (M_RVALID) begin
                        M_RREADY  <= 1'b0;
                        mem_rdata <= M_RDATA;
                        mem_err   <= resp_is_err(M_RRESP);
                        mem_ready <= 1'b1;
                        state     <= ST_DONE;
                    end else if (expired) begin
                        M_RREADY  <= 1'b0;
                        mem_err   <= 1'b1;
                        mem_rdata <= '0;
                        mem_ready <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    mem_ready <= 1'b0;
                    mem_err   <= 1'b0;
                    mem_rdata <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_lite_master.sv
// Directed bench for axil_lite_master: table of single transactions against a small AXI-Lite
// slave model, plus hand sequences for AW stall, timeout, reset mid-write and back-to-back traffic.
module tb_axil_lite_master;

    logic        aclk;
    logic        aresetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic [31:0] M_AWADDR;
    logic [2:0]  M_AWPROT;
    logic        M_AWVALID;
    logic        M_AWREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WVALID;
    logic        M_WREADY;
    logic [1:0]  M_BRESP;
    logic        M_BVALID;
    logic        M_BREADY;
    logic [31:0] M_ARADDR;
    logic [2:0]  M_ARPROT;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RVALID;
    logic        M_RREADY;

    axil_lite_master #(.TIMEOUT_CYCLES(15)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_wait;
        int          w_wait;
        int          rsp_delay;
        logic [1:0]  resp;
        bit          force_rd;
        logic [31:0] frdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Slave configuration and observation counters
    int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0, cfg_rsp_delay = 0;
    logic [1:0]  cfg_resp = 2'b00;
    bit          cfg_force = 0;
    logic [31:0] cfg_frdata = 32'h0;
    bit          mon_en = 1;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_ready = 0, viol = 0;
    logic [31:0] smem [0:31];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_outs();
        return {14'b0, M_ARPROT, M_AWPROT, M_WSTRB, mem_ready, mem_err, M_AWVALID,
                M_WVALID, M_BREADY, M_ARVALID, M_RREADY};
    endfunction

    function automatic logic [31:0] data_outs();
        return mem_rdata | M_AWADDR | M_WDATA | M_ARADDR;
    endfunction

    // Slave model and protocol monitor; all slave signals change on the falling edge.
    initial begin
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit aw_got, w_got, b_pending, r_pending, b_hs, r_hs;
        bit p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
        logic [31:0] aw_addr, w_data, ar_addr, p_awaddr, p_wdata, p_araddr;
        logic [3:0]  w_strb, p_wstrb;
        for (int i = 0; i < 32; i++) smem[i] = 32'h0;
        M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
        M_BRESP = 0; M_RRESP = 0; M_RDATA = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pending = 0; r_pending = 0; b_hs = 0; r_hs = 0;
        p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0;
        aw_addr = 0; w_data = 0; ar_addr = 0; w_strb = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; b_pending = 0; r_pending = 0; b_hs = 0; r_hs = 0;
                p_awv = 0; p_wv = 0; p_arv = 0;
            end else begin
                if (mem_ready) n_ready++;
                if (mon_en) begin
                    if (p_awv && !p_awhs && (!M_AWVALID || M_AWADDR != p_awaddr)) viol++;
                    if (p_wv && !p_whs && (!M_WVALID || M_WDATA != p_wdata || M_WSTRB != p_wstrb)) viol++;
                    if (p_arv && !p_arhs && (!M_ARVALID || M_ARADDR != p_araddr)) viol++;
                end
                // B channel
                if (M_BVALID && b_hs) begin M_BVALID = 0; b_hs = 0; end
                if (!M_BVALID && b_pending) begin
                    if (b_cnt >= cfg_rsp_delay) begin
                        M_BVALID = 1; M_BRESP = cfg_resp; b_pending = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                if (M_BVALID && M_BREADY && !b_hs) begin b_hs = 1; n_b++; end
                // R channel
                if (M_RVALID && r_hs) begin M_RVALID = 0; r_hs = 0; end
                if (!M_RVALID && r_pending) begin
                    if (r_cnt >= cfg_rsp_delay) begin
                        M_RVALID = 1; M_RRESP = cfg_resp; r_pending = 0; r_cnt = 0;
                        M_RDATA = cfg_force ? cfg_frdata : smem[ar_addr[6:2]];
                    end else r_cnt++;
                end
                if (M_RVALID && M_RREADY && !r_hs) begin r_hs = 1; n_r++; end
                // AW / W / AR
                M_AWREADY = 0;
                if (M_AWVALID) begin
                    if (aw_cnt >= cfg_aw_wait) begin
                        M_AWREADY = 1; aw_cnt = 0; aw_addr = M_AWADDR; aw_got = 1; n_aw++;
                    end else aw_cnt++;
                end else aw_cnt = 0;
                M_WREADY = 0;
                if (M_WVALID) begin
                    if (w_cnt >= cfg_w_wait) begin
                        M_WREADY = 1; w_cnt = 0; w_data = M_WDATA; w_strb = M_WSTRB; w_got = 1; n_w++;
                    end else w_cnt++;
                end else w_cnt = 0;
                if (aw_got && w_got) begin
                    for (int b = 0; b < 4; b++)
                        if (w_strb[b]) smem[aw_addr[6:2]][8*b +: 8] = w_data[8*b +: 8];
                    aw_got = 0; w_got = 0; b_pending = 1;
                end
                M_ARREADY = 0;
                if (M_ARVALID) begin
                    if (ar_cnt >= cfg_ar_wait) begin
                        M_ARREADY = 1; ar_cnt = 0; ar_addr = M_ARADDR; r_pending = 1; n_ar++;
                    end else ar_cnt++;
                end else ar_cnt = 0;
                p_awv = M_AWVALID; p_awhs = M_AWVALID && M_AWREADY; p_awaddr = M_AWADDR;
                p_wv  = M_WVALID;  p_whs  = M_WVALID && M_WREADY;   p_wdata = M_WDATA; p_wstrb = M_WSTRB;
                p_arv = M_ARVALID; p_arhs = M_ARVALID && M_ARREADY; p_araddr = M_ARADDR;
            end
        end
    end

    // Issues one request at the current falling edge, waits for mem_ready, checks, then releases.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit got;
        cfg_aw_wait = v.aw_wait; cfg_w_wait = v.w_wait; cfg_ar_wait = 0;
        cfg_rsp_delay = v.rsp_delay; cfg_resp = v.resp; cfg_force = v.force_rd; cfg_frdata = v.frdata;
        mem_valid = 1'b1;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wr ? v.wstrb : 4'h0;
        lat = 0; got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge aclk);
            lat++;
            if (mem_ready) got = 1;
        end
        chk("latency", idx, lat, v.exp_lat);
        chk("rdata", idx, mem_rdata, v.exp_rdata);
        chk("err", idx, {31'b0, mem_err}, {31'b0, v.exp_err});
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge aclk);
        chk("ready_pulse", idx, {31'b0, mem_ready}, 32'h0);
    endtask

    vec_t vecs [10];

    initial begin
        int lat, nb0, na0, nw0, nr0, nar0, nrdy0;
        bit got, arv1;
        vec_t v;

        vecs[0] = '{1'b1, 32'h04, 32'h0000_00FF, 4'hF, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h04, 32'h0,         4'h0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3, 32'h0000_00FF, 1'b0};
        vecs[2] = '{1'b1, 32'h0C, 32'hDEAD_BEEF, 4'hF, 0, 2, 0, 2'b10, 1'b0, 32'h0, 5, 32'h0, 1'b1};
        vecs[3] = '{1'b0, 32'h0C, 32'h0,         4'h0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{1'b0, 32'h3C, 32'h0,         4'h0, 0, 0, 0, 2'b10, 1'b1, 32'h1234_5678, 3, 32'h1234_5678, 1'b1};
        vecs[5] = '{1'b0, 32'h10, 32'h0,         4'h0, 0, 0, 2, 2'b11, 1'b0, 32'h0, 5, 32'h0, 1'b1};
        vecs[6] = '{1'b1, 32'h04, 32'h00AB_0000, 4'h4, 1, 1, 0, 2'b00, 1'b0, 32'h0, 4, 32'h0, 1'b0};
        vecs[7] = '{1'b0, 32'h04, 32'h0,         4'h0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3, 32'h00AB_00FF, 1'b0};
        vecs[8] = '{1'b1, 32'h14, 32'h0000_0011, 4'h1, 0, 0, 0, 2'b01, 1'b0, 32'h0, 3, 32'h0, 1'b1};
        vecs[9] = '{1'b0, 32'h14, 32'h0,         4'h0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3, 32'h0000_0011, 1'b0};

        aresetn = 1'b0; mem_valid = 1'b0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        repeat (3) @(negedge aclk);
        chk("reset_ctrl", 0, ctrl_outs(), 32'h0);
        chk("reset_data", 0, data_outs(), 32'h0);
        aresetn = 1'b1;
        @(negedge aclk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // AWREADY held low three cycles after the W handshake
        cfg_aw_wait = 3; cfg_w_wait = 0; cfg_rsp_delay = 0; cfg_resp = 2'b00; cfg_force = 0;
        nb0 = n_b; na0 = n_aw; nw0 = n_w;
        mem_valid = 1'b1; mem_addr = 32'h08; mem_wdata = 32'hA5A5_1234; mem_wstrb = 4'h3;
        lat = 0; got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge aclk);
            lat++;
            if (lat == 2) begin
                chk("wvalid_cleared", 0, {31'b0, M_WVALID}, 32'h0);
                chk("awvalid_held", 0, {31'b0, M_AWVALID}, 32'h1);
            end
            if (lat == 4) chk("awvalid_held", 1, {31'b0, M_AWVALID}, 32'h1);
            if (mem_ready) got = 1;
        end
        chk("aw_stall_latency", 0, lat, 6);
        chk("aw_stall_err", 0, {31'b0, mem_err}, 32'h0);
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        @(negedge aclk);
        chk("aw_stall_counts", 0, {8'(n_aw - na0), 8'(n_w - nw0), 8'(n_b - nb0), 8'h0}, 32'h0101_0100);
        v = '{1'b0, 32'h08, 32'h0, 4'h0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3, 32'h0000_1234, 1'b0};
        run_vec(v, 20);

        // Slave that never accepts AR
        mon_en = 0; cfg_ar_wait = 1000000; cfg_resp = 2'b00;
        mem_valid = 1'b1; mem_addr = 32'h40; mem_wstrb = 4'h0;
        lat = 0; got = 0; arv1 = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge aclk);
            lat++;
            if (lat == 1) arv1 = M_ARVALID;
            if (mem_ready) got = 1;
        end
        chk("to_arvalid_rise", 0, {31'b0, arv1}, 32'h1);
`ifdef AXIL_MASTER_TIMEOUT_EN
        chk("to_latency", 0, lat, 17);
        chk("to_arvalid_drop", 0, {31'b0, M_ARVALID}, 32'h0);
        chk("to_err", 0, {31'b0, mem_err}, 32'h1);
        chk("to_rdata", 0, mem_rdata, 32'h0);
        mem_valid = 1'b0;
        @(negedge aclk);
`else
        chk("to_no_ready", 0, {31'b0, got}, 32'h0);
        chk("to_arvalid_hold", 0, {31'b0, M_ARVALID}, 32'h1);
        mem_valid = 1'b0;
        #2 aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
`endif
        cfg_ar_wait = 0; mon_en = 1;

        // Reset asserted while waiting for B
        cfg_rsp_delay = 50;
        mem_valid = 1'b1; mem_addr = 32'h18; mem_wdata = 32'h77; mem_wstrb = 4'hF;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge aclk);
            if (M_BREADY) got = 1;
        end
        chk("rst_reach_wr_resp", 0, {31'b0, got}, 32'h1);
        mon_en = 0;
        nrdy0 = n_ready;
        #2 aresetn = 1'b0;
        #1;
        chk("rst_async_ctrl", 0, ctrl_outs(), 32'h0);
        chk("rst_async_data", 0, data_outs(), 32'h0);
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        cfg_rsp_delay = 0;
        repeat (3) @(negedge aclk);
        chk("rst_no_ready", 0, n_ready - nrdy0, 0);
        mon_en = 1;
        v = '{1'b1, 32'h18, 32'h0000_0099, 4'hF, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3, 32'h0, 1'b0};
        run_vec(v, 30);
        v = '{1'b0, 32'h18, 32'h0, 4'h0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3, 32'h0000_0099, 1'b0};
        run_vec(v, 31);

        // Back-to-back alternating write/read at minimum spacing
        na0 = n_aw; nw0 = n_w; nb0 = n_b; nar0 = n_ar; nr0 = n_r; nrdy0 = n_ready;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, d;
            a = 32'h40 + 32'(i / 2) * 4;
            d = 32'hC0DE_0000 + 32'(i - (i % 2));
            if (i % 2 == 0) v = '{1'b1, a, d, 4'hF, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3, 32'h0, 1'b0};
            else            v = '{1'b0, a, 32'h0, 4'h0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3, d, 1'b0};
            run_vec(v, 40 + i);
        end
        chk("b2b_aw_w_b", 0, {8'(n_aw - na0), 8'(n_w - nw0), 8'(n_b - nb0), 8'h0}, 32'h0404_0400);
        chk("b2b_ar_r", 0, {16'h0, 8'(n_ar - nar0), 8'(n_r - nr0)}, 32'h0000_0404);
        chk("b2b_ready_pulses", 0, n_ready - nrdy0, 8);

        chk("protocol_violations", 0, viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_lite_master.md
# axil_lite_master

Bridge from the core's native valid/ready memory port to an AXI4-Lite master interface. One request in flight at a time: each request becomes exactly one AXI4-Lite write (AW+W+B) or read (AR+R). The result returns as a single-cycle `mem_ready` pulse. It sits between the CPU (or a DMA-style requester) and the AXI-Lite interconnect that feeds the GPIO and other peripheral slaves.

## Interface
- `TIMEOUT_CYCLES`, default 1023: watchdog limit in cycles. Used only when `AXIL_MASTER_TIMEOUT_EN` is defined.
- `aclk` in 1: single clock; all logic on its rising edge.
- `aresetn` in 1: reset, asynchronous, active-low.
- `mem_valid` in 1: request present. Held with its payload until `mem_ready`.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte enables. Nonzero means write; zero means read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data, valid while `mem_ready` is high. Zero for writes.
- `mem_err` out 1: high with `mem_ready` when BRESP/RRESP ≠ OKAY, or on timeout.
- `M_AWADDR` out 32, `M_AWPROT` out 3, `M_AWVALID` out 1, `M_AWREADY` in 1
- `M_WDATA` out 32, `M_WSTRB` out 4, `M_WVALID` out 1, `M_WREADY` in 1
- `M_BRESP` in 2, `M_BVALID` in 1, `M_BREADY` out 1
- `M_ARADDR` out 32, `M_ARPROT` out 3, `M_ARVALID` out 1, `M_ARREADY` in 1
- `M_RDATA` in 32, `M_RRESP` in 2, `M_RVALID` in 1, `M_RREADY` out 1

## Operation
- All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE.
- `M_*PROT` is constant 3'b000.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- **IDLE**
  - `mem_valid` with `mem_wstrb != 0` → WR_REQ. Load AWADDR/WDATA/WSTRB, set AWVALID=WVALID=1.
  - `mem_valid` with `mem_wstrb == 0` → RD_REQ. Load ARADDR, set ARVALID=1.
- **WR_REQ**
  - AWVALID clears on its own handshake (AWVALID&&AWREADY); WVALID clears on its own handshake. The two are independent.
  - AW and W may complete in the same cycle or in any order.
  - When both have completed → WR_RESP with BREADY=1.
- **WR_RESP**
  - On BVALID: BREADY←0, `mem_err`←(BRESP≠0), `mem_rdata`←0 → DONE.
- **RD_REQ**
  - On ARVALID&&ARREADY: ARVALID←0, RREADY←1 → RD_RESP.
- **RD_RESP**
  - On RVALID: RREADY←0, `mem_rdata`←RDATA (captured even on error), `mem_err`←(RRESP≠0) → DONE.
- **DONE**
  - `mem_ready`=1 for exactly this cycle → IDLE.
  - The requester drops `mem_valid` on the same edge that samples `mem_ready`, so IDLE never re-issues the request.
- A VALID is never deasserted before its handshake, except on reset or timeout.
- Address and data are never changed while their VALID is high.
- Reset mid-transaction: all VALID/READY outputs drop immediately (asynchronous) and the FSM returns to IDLE. The in-flight request is lost and no `mem_ready` is produced.

## Timing
- Slave with READY tied high and a one-cycle response:
  - Read: ARVALID in cycle 1, RVALID in cycle 2, `mem_ready` in cycle 3.
  - Write: AW/W in cycle 1, BVALID in cycle 2, `mem_ready` in cycle 3.
- `mem_ready` always rises exactly one cycle after the B or R handshake cycle.
- Minimum spacing between back-to-back requests: `mem_ready` cycle, then one IDLE cycle, then the next VALID.

## Configuration
- `AXIL_MASTER_TIMEOUT_EN` defined:
  - A counter, width $clog2(TIMEOUT_CYCLES+1), clears on leaving IDLE and increments in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When the count reaches TIMEOUT_CYCLES: all VALID/READY outputs ←0, `mem_err`←1, `mem_rdata`←0, → DONE.
  - Dropping VALID without a handshake here is an accepted protocol violation for a hung slave.
  - If a handshake and the timeout occur in the same cycle, the handshake wins.
- Not defined: no counter is built; the FSM waits indefinitely. `mem_err` comes from BRESP/RRESP only.

## Structure
- Shared package `axil_pkg` holds:
  - RESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - State enum.
  - Default PROT constant.
- One sub-module, `axil_watchdog` (counter plus expiry flag), instantiated only under `AXIL_MASTER_TIMEOUT_EN`.

## Test plan
- Write 0x0000_00FF to 0x04, strobe 0xF, with the GPIO slave attached. Expect one AW and one W handshake, `mem_ready` one cycle after B, `mem_err`=0, and a later read of 0x04 returning 0x0000_00FF.
- Write where the slave holds AWREADY low for 3 cycles after WREADY. Expect WVALID to clear after its own handshake, AWVALID to hold until its handshake, and exactly one B accepted.
- Read from 0x3C where the slave returns RRESP=2'b10 and RDATA=0x1234_5678. Expect `mem_ready`=1, `mem_err`=1, `mem_rdata`=0x1234_5678.
- With TIMEOUT_CYCLES=15 and the macro on, a slave that never asserts ARREADY. Expect ARVALID to drop and `mem_ready`+`mem_err` to fire 16 cycles after ARVALID rose. With the macro off, ARVALID stays high.
- `aresetn` low during WR_RESP. Expect all outputs 0 asynchronously, no `mem_ready`, and the next request to complete normally.
- 8 back-to-back alternating reads and writes. Expect exactly 8 AXI transactions and 8 `mem_ready` pulses, with no duplicate issue.
